// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main register drives the output, skid catches the
// beat accepted while downstream stalls, so in_ready is purely registered.
module pipe_skid_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q = EMPTY;
   logic [WIDTH-1:0] main_q  = '0;
   logic [WIDTH-1:0] skid_q  = '0;
   logic             vld_q   = 1'b0;
   logic             full_q  = 1'b0;

   logic in_xfer;
   logic out_xfer;

   assign in_xfer   = in_valid && !full_q;
   assign out_xfer  = vld_q && out_ready;

   assign in_ready  = !full_q;
   assign out_valid = vld_q;
   assign out_data  = main_q;

   // vld_q/full_q mirror the state so the handshake outputs come straight off flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         vld_q   <= 1'b0;
         full_q  <= 1'b0;
      end else if (flush) begin
         state_q <= EMPTY;
         vld_q   <= 1'b0;
         full_q  <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_xfer) begin
                  main_q  <= in_data;
                  state_q <= ONE;
                  vld_q   <= 1'b1;
               end
            end
            ONE: begin
               if (in_xfer && !out_xfer) begin
                  skid_q  <= in_data;
                  state_q <= FULL;
                  full_q  <= 1'b1;
               end else if (!in_xfer && out_xfer) begin
                  state_q <= EMPTY;
                  vld_q   <= 1'b0;
               end else if (in_xfer && out_xfer) begin
                  main_q  <= in_data;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  main_q  <= skid_q;
                  state_q <= ONE;
                  full_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= EMPTY;
               vld_q   <= 1'b0;
               full_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Randomized and directed bench for pipe_skid_reg against a queue-based
// model of a two-deep FIFO with flush and reset.
module tb_pipe_skid_reg;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic [WIDTH-1:0] in_data = '0;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [WIDTH-1:0] mq[$];   // model contents, head first
   logic [WIDTH-1:0] got[$];  // DUT output transfers observed

   pipe_skid_reg #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: reset/flush empty the FIFO; otherwise pop then push by handshake rules.
   task automatic model_edge(input logic r, input logic f, input logic iv,
                             input logic [WIDTH-1:0] id, input logic ordy);
      bit in_x, out_x;
      if (r || f) begin
         mq.delete();
      end else begin
         in_x  = iv && (mq.size() < 2);
         out_x = (mq.size() > 0) && ordy;
         if (out_x) void'(mq.pop_front());
         if (in_x) mq.push_back(id);
      end
   endtask

   task automatic compare();
      chk("out_valid", WIDTH'(out_valid), WIDTH'(mq.size() > 0));
      chk("in_ready", WIDTH'(in_ready), WIDTH'(mq.size() < 2));
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
   endtask

   // Inputs are set at the falling edge; outputs are sampled there too.
   task automatic tick();
      logic r, f, iv, ordy;
      logic [WIDTH-1:0] id;
      r = rst; f = flush; iv = in_valid; id = in_data; ordy = out_ready;
      if (out_valid && out_ready && !rst && !flush) got.push_back(out_data);
      @(posedge clk);
      model_edge(r, f, iv, id, ordy);
      @(negedge clk);
      compare();
   endtask

   task automatic send(input logic [WIDTH-1:0] d);
      bit acc;
      in_valid = 1'b1;
      in_data  = d;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         acc = in_ready;
         tick();
      end
      if (!acc) chk("send_timeout", '0, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      #1;
      chk("pwr_out_valid", WIDTH'(out_valid), '0);
      chk("pwr_in_ready", WIDTH'(in_ready), 1);
      chk("pwr_out_data", out_data, '0);
      @(negedge clk);

      // reset then idle
      rst = 1'b1; tick(); rst = 1'b0;
      tick(); tick();
      chk("rst_out_data", out_data, '0);
      chk("rst_out_valid", WIDTH'(out_valid), '0);

      // three successive offers with downstream stalled
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 32'h11; tick();
      in_data = 32'h22; tick();
      chk("full_in_ready", WIDTH'(in_ready), '0);
      chk("full_head", out_data, 32'h11);
      in_data = 32'h33; tick();
      chk("reject_head", out_data, 32'h11);
      got.delete();
      out_ready = 1'b1;
      begin
         bit acc;
         acc = 1'b0;
         for (int i = 0; i < 10 && !acc; i++) begin
            acc = in_ready;
            tick();
         end
         if (!acc) chk("hold33_timeout", '0, 1);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("drain_n", WIDTH'(got.size()), 3);
      if (got.size() == 3) begin
         chk("drain0", got[0], 32'h11);
         chk("drain1", got[1], 32'h22);
         chk("drain2", got[2], 32'h33);
      end

      // full-rate stream
      got.delete();
      out_ready = 1'b1; in_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_data = WIDTH'(i);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("stream_n", WIDTH'(got.size()), 8);
      for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_val", got[i], WIDTH'(i + 1));
      tick();
      chk("stream_more", WIDTH'(got.size()), 8);

      // flush in FULL together with an offered beat
      out_ready = 1'b0;
      send(32'hA1); send(32'hA2);
      chk("pre_flush_full", WIDTH'(in_ready), '0);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h44;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_out_valid", WIDTH'(out_valid), '0);
      chk("flush_in_ready", WIDTH'(in_ready), 1);
      got.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("flush_no44", WIDTH'(got.size()), '0);

      // rst and flush together in FULL
      out_ready = 1'b0;
      send(32'hB1); send(32'hB2);
      rst = 1'b1; flush = 1'b1;
      tick();
      rst = 1'b0; flush = 1'b0;
      chk("rstfl_out_data", out_data, '0);
      chk("rstfl_out_valid", WIDTH'(out_valid), '0);
      in_valid = 1'b1; in_data = 32'h55;
      tick();
      in_valid = 1'b0;
      chk("post_rst_valid", WIDTH'(out_valid), 1);
      chk("post_rst_data", out_data, 32'h55);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 55);
         in_data   = $urandom;
         flush     = ($urandom_range(0, 99) < 3);
         rst       = ($urandom_range(0, 199) < 2);
         tick();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, setting the width of the data path in bits.
REQ-002 The module SHALL have port clk, input, 1 bit, the clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-004 The module SHALL have port flush, input, 1 bit, a synchronous discard of all held entries.
REQ-005 The module SHALL have port in_valid, input, 1 bit, indicating the upstream offers in_data.
REQ-006 The module SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-007 The module SHALL have port in_ready, output, 1 bit, indicating the block accepts input this cycle; it is registered.
REQ-008 The module SHALL have port out_valid, output, 1 bit, indicating out_data holds a valid entry; it is registered.
REQ-009 The module SHALL have port out_data, output, WIDTH bits, the head entry; it is registered.
REQ-010 The module SHALL have port out_ready, input, 1 bit, indicating the downstream consumes out_data this cycle.

Function
REQ-011 An input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-012 Storage SHALL be two entries: a main register (drives out_data) and a skid register; the state SHALL be one of EMPTY, ONE or FULL.
REQ-013 EMPTY: out_valid=0 and in_ready=1; an input transfer loads the main register and moves to ONE.
REQ-014 ONE: out_valid=1 and in_ready=1; input only moves to FULL (data into skid); output only moves to EMPTY; input and output together reload main with in_data and stay in ONE.
REQ-015 FULL: out_valid=1 and in_ready=0; an output transfer moves skid to main and returns to ONE; with no output transfer, state and data hold.
REQ-016 in_ready SHALL depend only on registered state, never combinationally on out_ready.
REQ-017 Latency SHALL be 1 cycle: data accepted at edge N is on out_data with out_valid=1 from edge N onward when the block was EMPTY.
REQ-018 Order SHALL be strictly first-in first-out; no entry is dropped or duplicated except by flush or rst.
REQ-019 With in_valid=1 and out_ready=1 held continuously, throughput SHALL be one transfer per cycle.
REQ-020 out_data SHALL hold its value while out_valid=1 and out_ready=0.
REQ-021 When flush=1 at an edge, the state SHALL become EMPTY; any input transfer or output transfer in that cycle is discarded; data registers keep their values.
REQ-022 in_valid=1 while in_ready=0 SHALL have no effect.

Reset
REQ-023 When rst=1 at an edge, the state SHALL become EMPTY with out_valid=0, in_ready=1 and out_data=0, and the skid register SHALL become 0.
REQ-024 rst SHALL take priority over flush and over any simultaneous transfer.
REQ-025 All registers SHALL also be 0 at power-up (simulation initial value), with state EMPTY.

Verification
REQ-026 Reset then idle -> out_valid=0, in_ready=1, out_data=0.
REQ-027 Send 0x11, 0x22 and 0x33 on successive cycles with out_ready=0 -> after the 2nd edge in_ready=0 and out_data=0x11; 0x33 is not accepted.
REQ-028 Then set out_ready=1 while holding 0x33 on the input -> outputs appear in order 0x11, 0x22, 0x33 with no loss or duplicate.
REQ-029 Stream values 1..8 with in_valid=1 and out_ready=1 held -> 8 outputs on 8 consecutive cycles, in order.
REQ-030 In the FULL state assert flush together with in_valid=1 carrying 0x44 -> next cycle out_valid=0 and in_ready=1; 0x44 never appears on the output.
REQ-031 In the FULL state assert rst and flush together -> EMPTY with out_data=0; a following 0x55 emerges after 1 cycle.
